// File: rtl/wb_pkg.sv
// Shared widths and state encoding for the two-master Wishbone arbiter.
package wb_pkg;
  localparam int WB_ADR_W = 64;
  localparam int WB_DAT_W = 64;
  localparam int WB_SEL_W = 8;
  localparam int OUTST_W  = 4;
  localparam int WDOG_W   = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    ABORT  = 2'd3
  } arb_state_e;
endpackage

// File: rtl/wb_watchdog.sv
// Ack watchdog: counts stalled-response cycles and flags expiry at TIMEOUT_CYCLES.
module wb_watchdog
  import wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(TIMEOUT_CYCLES);

  logic [WDOG_W-1:0] count_q, count_d;

  assign o_expired = (count_q == LIMIT);

  // Saturate at the limit so expiry stays visible until the arbiter reacts.
  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_enable && !o_expired) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Two-master round-robin Wishbone arbiter with outstanding-strobe limit and ack watchdog.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES  = 255,
  parameter int MAX_OUTSTANDING = 15
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_m0_cyc,
  input  logic                i_m0_stb,
  input  logic                i_m0_we,
  input  logic [WB_ADR_W-1:0] i_m0_adr,
  input  logic [WB_DAT_W-1:0] i_m0_dat,
  input  logic [WB_SEL_W-1:0] i_m0_sel,
  input  logic                i_m1_cyc,
  input  logic                i_m1_stb,
  input  logic                i_m1_we,
  input  logic [WB_ADR_W-1:0] i_m1_adr,
  input  logic [WB_DAT_W-1:0] i_m1_dat,
  input  logic [WB_SEL_W-1:0] i_m1_sel,
  output logic [WB_DAT_W-1:0] o_m0_dat,
  output logic                o_m0_ack,
  output logic                o_m0_stall,
  output logic                o_m0_err,
  output logic [WB_DAT_W-1:0] o_m1_dat,
  output logic                o_m1_ack,
  output logic                o_m1_stall,
  output logic                o_m1_err,
  output logic                o_wb_cyc,
  output logic                o_wb_stb,
  output logic                o_wb_we,
  output logic [WB_ADR_W-1:0] o_wb_adr,
  output logic [WB_DAT_W-1:0] o_wb_dat,
  output logic [WB_SEL_W-1:0] o_wb_sel,
  input  logic [WB_DAT_W-1:0] i_wb_dat,
  input  logic                i_wb_ack,
  input  logic                i_wb_stall
);

  localparam logic [OUTST_W-1:0] OUTST_MAX = OUTST_W'(MAX_OUTSTANDING);

  arb_state_e         state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic [OUTST_W-1:0] outst_q, outst_d;

  logic granted, aborting, own1, own_cyc, own_stb;
  logic full, has_outst, fwd_ack, accept;
  logic wdog_clear, wdog_expired;

  // Reset gates the response path so outputs are idle while reset is held.
  assign granted   = !i_reset && (state_q == GRANT0 || state_q == GRANT1);
  assign aborting  = !i_reset && (state_q == ABORT);
  assign own1      = (state_q == GRANT1);
  assign own_cyc   = own1 ? i_m1_cyc : i_m0_cyc;
  assign own_stb   = own1 ? i_m1_stb : i_m0_stb;
  assign full      = (outst_q == OUTST_MAX);
  assign has_outst = (outst_q != '0);

  assign o_wb_cyc = granted & own_cyc;
  assign o_wb_stb = granted & own_stb & ~full;
  assign o_wb_we  = own1 ? i_m1_we  : i_m0_we;
  assign o_wb_adr = own1 ? i_m1_adr : i_m0_adr;
  assign o_wb_dat = own1 ? i_m1_dat : i_m0_dat;
  assign o_wb_sel = own1 ? i_m1_sel : i_m0_sel;

  assign fwd_ack = granted & i_wb_ack & has_outst;
  assign accept  = o_wb_stb & ~i_wb_stall;

  assign o_m0_dat   = i_wb_dat;
  assign o_m1_dat   = i_wb_dat;
  assign o_m0_ack   = fwd_ack & ~own1;
  assign o_m1_ack   = fwd_ack & own1;
  assign o_m0_stall = (granted && !own1) ? (i_wb_stall | full) : 1'b1;
  assign o_m1_stall = (granted &&  own1) ? (i_wb_stall | full) : 1'b1;
  assign o_m0_err   = aborting & ~last_grant_q;
  assign o_m1_err   = aborting &  last_grant_q;

  assign wdog_clear = i_wb_ack | ~has_outst | ~granted;

  wb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (wdog_clear),
    .i_enable  (granted),
    .o_expired (wdog_expired)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    outst_d      = outst_q;
    case (state_q)
      IDLE: begin
        outst_d = '0;
        if (i_m0_cyc && i_m1_cyc) begin
          state_d = last_grant_q ? GRANT0 : GRANT1;
        end else if (i_m0_cyc) begin
          state_d = GRANT0;
        end else if (i_m1_cyc) begin
          state_d = GRANT1;
        end
      end
      GRANT0, GRANT1: begin
        if (accept && !fwd_ack) begin
          outst_d = outst_q + 1'b1;
        end else if (!accept && fwd_ack) begin
          outst_d = outst_q - 1'b1;
        end
        // Expiry wins over a simultaneous release so the owner still sees err.
        if (wdog_expired) begin
          state_d      = ABORT;
          last_grant_d = own1;
          outst_d      = '0;
        end else if (!own_cyc) begin
          state_d      = IDLE;
          last_grant_d = own1;
        end
      end
      ABORT: begin
        state_d = IDLE;
        outst_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      outst_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      outst_q      <= outst_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: vector table, directed corner sequences, randomized model run.
module tb_wb_arbiter;
  import wb_pkg::*;

  localparam int MAXO    = 15;
  localparam int TO_MAIN = 255;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic i_reset;
  logic i_m0_cyc, i_m0_stb, i_m0_we, i_m1_cyc, i_m1_stb, i_m1_we;
  logic [WB_ADR_W-1:0] i_m0_adr, i_m1_adr;
  logic [WB_DAT_W-1:0] i_m0_dat, i_m1_dat, i_wb_dat;
  logic [WB_SEL_W-1:0] i_m0_sel, i_m1_sel;
  logic i_wb_ack, i_wb_stall;

  logic [WB_DAT_W-1:0] o_m0_dat, o_m1_dat, o_wb_dat;
  logic o_m0_ack, o_m0_stall, o_m0_err, o_m1_ack, o_m1_stall, o_m1_err;
  logic o_wb_cyc, o_wb_stb, o_wb_we;
  logic [WB_ADR_W-1:0] o_wb_adr;
  logic [WB_SEL_W-1:0] o_wb_sel;

  logic [WB_DAT_W-1:0] t_m0_dat, t_m1_dat, t_wb_dat;
  logic t_m0_ack, t_m0_stall, t_m0_err, t_m1_ack, t_m1_stall, t_m1_err;
  logic t_wb_cyc, t_wb_stb, t_wb_we;
  logic [WB_ADR_W-1:0] t_wb_adr;
  logic [WB_SEL_W-1:0] t_wb_sel;

  wb_arbiter dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_m0_cyc(i_m0_cyc), .i_m0_stb(i_m0_stb), .i_m0_we(i_m0_we),
    .i_m0_adr(i_m0_adr), .i_m0_dat(i_m0_dat), .i_m0_sel(i_m0_sel),
    .i_m1_cyc(i_m1_cyc), .i_m1_stb(i_m1_stb), .i_m1_we(i_m1_we),
    .i_m1_adr(i_m1_adr), .i_m1_dat(i_m1_dat), .i_m1_sel(i_m1_sel),
    .o_m0_dat(o_m0_dat), .o_m0_ack(o_m0_ack), .o_m0_stall(o_m0_stall), .o_m0_err(o_m0_err),
    .o_m1_dat(o_m1_dat), .o_m1_ack(o_m1_ack), .o_m1_stall(o_m1_stall), .o_m1_err(o_m1_err),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel),
    .i_wb_dat(i_wb_dat), .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall)
  );

  // Short-timeout instance sharing the same stimulus; only observed in the timeout sequence.
  wb_arbiter #(.TIMEOUT_CYCLES(8)) dut_t (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_m0_cyc(i_m0_cyc), .i_m0_stb(i_m0_stb), .i_m0_we(i_m0_we),
    .i_m0_adr(i_m0_adr), .i_m0_dat(i_m0_dat), .i_m0_sel(i_m0_sel),
    .i_m1_cyc(i_m1_cyc), .i_m1_stb(i_m1_stb), .i_m1_we(i_m1_we),
    .i_m1_adr(i_m1_adr), .i_m1_dat(i_m1_dat), .i_m1_sel(i_m1_sel),
    .o_m0_dat(t_m0_dat), .o_m0_ack(t_m0_ack), .o_m0_stall(t_m0_stall), .o_m0_err(t_m0_err),
    .o_m1_dat(t_m1_dat), .o_m1_ack(t_m1_ack), .o_m1_stall(t_m1_stall), .o_m1_err(t_m1_err),
    .o_wb_cyc(t_wb_cyc), .o_wb_stb(t_wb_stb), .o_wb_we(t_wb_we),
    .o_wb_adr(t_wb_adr), .o_wb_dat(t_wb_dat), .o_wb_sel(t_wb_sel),
    .i_wb_dat(i_wb_dat), .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // {rst, m0_cyc, m0_stb, m1_cyc, m1_stb, wb_ack, wb_stall}; inputs change at negedge, sampled 2ns later.
  task automatic drive(input logic [6:0] v);
    @(negedge i_clk);
    {i_reset, i_m0_cyc, i_m0_stb, i_m1_cyc, i_m1_stb, i_wb_ack, i_wb_stall} = v;
    #2;
  endtask

  function automatic logic [7:0] obs();
    return {o_wb_cyc, o_wb_stb, o_m0_ack, o_m1_ack, o_m0_stall, o_m1_stall, o_m0_err, o_m1_err};
  endfunction

  typedef struct packed {
    logic [6:0] in;
    logic [7:0] exp;
  } vec_t;

  vec_t vt[17];

  // Reference model state: who owns the bus, pending abort, last owner, strobes in flight, silent cycles.
  int m_owner, m_abort, m_last, m_pend, m_silent;

  initial begin
    logic [7:0] e;
    logic       c[2], s[2];
    logic       full, estb, ackf, acc;
    int         owner, k;
    bit         found;

    i_reset = 1'b1;
    {i_m0_cyc, i_m0_stb, i_m0_we, i_m1_cyc, i_m1_stb, i_m1_we} = '0;
    i_m0_adr = '0; i_m1_adr = '0; i_m0_dat = '0; i_m1_dat = '0;
    i_m0_sel = '0; i_m1_sel = '0; i_wb_dat = '0;
    i_wb_ack = 1'b0; i_wb_stall = 1'b0;

    vt[0]  = '{7'b1000000, 8'h0C};
    vt[1]  = '{7'b0110000, 8'h0C};
    vt[2]  = '{7'b0110000, 8'hC4};
    vt[3]  = '{7'b0100010, 8'hA4};
    vt[4]  = '{7'b0000000, 8'h04};
    vt[5]  = '{7'b0000010, 8'h0C};
    vt[6]  = '{7'b1101000, 8'h0C};
    vt[7]  = '{7'b0101000, 8'h0C};
    vt[8]  = '{7'b0111000, 8'hC4};
    vt[9]  = '{7'b0101010, 8'hA4};
    vt[10] = '{7'b0001000, 8'h04};
    vt[11] = '{7'b0001100, 8'h0C};
    vt[12] = '{7'b0001110, 8'hC8};
    vt[13] = '{7'b0001010, 8'h98};
    vt[14] = '{7'b0001101, 8'hCC};
    vt[15] = '{7'b0000000, 8'h08};
    vt[16] = '{7'b0000000, 8'h0C};

    drive(7'b1000000);
    drive(7'b1000000);
    for (int i = 0; i < 17; i++) begin
      drive(vt[i].in);
      chk($sformatf("vec%0d", i), 64'(obs()), 64'(vt[i].exp));
    end

    // Round-robin: both masters keep requesting; each releases after two transfers.
    drive(7'b1000000);
    for (int t = 0; t < 4; t++) begin
      found = 1'b0;
      owner = 0;
      for (int w = 0; w < 5 && !found; w++) begin
        drive(7'b0101000);
        if (!o_m0_stall || !o_m1_stall) begin
          found = 1'b1;
          owner = o_m0_stall ? 1 : 0;
        end
      end
      chk("rr_grant_seen", 64'(found), 64'(1));
      chk($sformatf("rr_owner%0d", t), 64'(owner), 64'(t % 2));
      for (int x = 0; x < 2; x++) begin
        drive(owner == 0 ? 7'b0111000 : 7'b0101100);
        drive(7'b0101010);
        chk("rr_ack", 64'(owner == 0 ? o_m0_ack : o_m1_ack), 64'(1));
      end
      drive(owner == 0 ? 7'b0001000 : 7'b0100000);
    end

    // Pipelining limit: 15 strobes accepted with ack withheld, the 16th stalled.
    drive(7'b1000000);
    drive(7'b0001100);
    for (int i = 0; i < 16; i++) begin
      drive(7'b0001100);
      if (i < MAXO) begin
        chk("pipe_accept", 64'({o_wb_stb, o_m1_stall}), 64'(2'b10));
      end else begin
        chk("pipe_full", 64'({o_wb_stb, o_m1_stall}), 64'(2'b01));
      end
    end
    k = 0;
    for (int i = 0; i < MAXO; i++) begin
      drive(7'b0001010);
      if (o_m1_ack) k++;
    end
    chk("pipe_acks", 64'(k), 64'(MAXO));
    drive(7'b0001010);
    chk("pipe_extra_ack", 64'(o_m1_ack), 64'(0));

    // Reset mid-burst with three strobes in flight.
    drive(7'b1000000);
    drive(7'b0110000);
    for (int i = 0; i < 3; i++) drive(7'b0110000);
    drive(7'b1100000);
    chk("rst_during", 64'(obs()), 64'(8'h0C));
    drive(7'b0100000);
    chk("rst_after", 64'(obs()), 64'(8'h0C));
    drive(7'b0100010);
    chk("rst_cnt_clear", 64'({o_wb_cyc, o_m0_ack}), 64'(2'b10));

    // Watchdog on the TIMEOUT_CYCLES=8 instance; owner releases in the expiry cycle.
    drive(7'b1000000);
    i_m0_adr = 64'h2_0000_0000;
    drive(7'b0110000);
    drive(7'b0110000);
    chk("to_adr", t_wb_adr, 64'h2_0000_0000);
    chk("to_stb", 64'({t_wb_cyc, t_wb_stb}), 64'(2'b11));
    found = 1'b0;
    k = 0;
    for (int w = 1; w <= 20 && !found; w++) begin
      drive(w == 9 ? 7'b0000000 : 7'b0100000);
      if (t_m0_err) begin
        found = 1'b1;
        k = w;
        chk("to_abort_cyc", 64'({t_wb_cyc, t_m1_err}), 64'(0));
      end
    end
    chk("to_err_seen", 64'(found), 64'(1));
    chk("to_err_delay", 64'(k), 64'(10));
    drive(7'b0000010);
    chk("to_err_pulse", 64'(t_m0_err), 64'(0));
    chk("to_late_ack", 64'(t_m0_ack), 64'(0));
    i_m0_adr = '0;

    // Randomized run against the behavioural model (TIMEOUT 255, MAX 15).
    m_owner = -1; m_abort = -1; m_last = 1; m_pend = 0; m_silent = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge i_clk);
      i_reset = (n == 0) || ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 7) == 0) i_m0_cyc = ~i_m0_cyc;
      if ($urandom_range(0, 7) == 0) i_m1_cyc = ~i_m1_cyc;
      i_m0_stb   = 1'($urandom_range(0, 1));
      i_m1_stb   = 1'($urandom_range(0, 1));
      i_m0_we    = 1'($urandom_range(0, 1));
      i_m1_we    = 1'($urandom_range(0, 1));
      i_wb_ack   = ($urandom_range(0, 9) < 4);
      i_wb_stall = ($urandom_range(0, 9) < 3);
      i_m0_adr   = {$urandom, $urandom};
      i_m1_adr   = {$urandom, $urandom};
      i_m0_dat   = {$urandom, $urandom};
      i_m1_dat   = {$urandom, $urandom};
      i_m0_sel   = 8'($urandom);
      i_m1_sel   = 8'($urandom);
      i_wb_dat   = {$urandom, $urandom};
      #2;
      c[0] = i_m0_cyc; c[1] = i_m1_cyc; s[0] = i_m0_stb; s[1] = i_m1_stb;
      full = 1'b0; estb = 1'b0; ackf = 1'b0;
      e = 8'h0C;
      if (!i_reset && m_abort >= 0) begin
        e = {6'b000011, m_abort == 0, m_abort == 1};
      end else if (!i_reset && m_owner >= 0) begin
        full = (m_pend == MAXO);
        estb = s[m_owner] && !full;
        ackf = i_wb_ack && (m_pend > 0);
        e = {c[m_owner], estb, m_owner == 0 && ackf, m_owner == 1 && ackf,
             m_owner == 0 ? (i_wb_stall || full) : 1'b1,
             m_owner == 1 ? (i_wb_stall || full) : 1'b1, 2'b00};
      end
      chk("rnd_ctl", 64'(obs()), 64'(e));
      chk("rnd_rdat", {o_m0_dat ^ o_m1_dat}, 64'(0) | (o_m0_dat ^ i_wb_dat));
      if (!i_reset && m_owner >= 0) begin
        chk("rnd_adr", o_wb_adr, m_owner == 0 ? i_m0_adr : i_m1_adr);
        chk("rnd_wdat", o_wb_dat, m_owner == 0 ? i_m0_dat : i_m1_dat);
        chk("rnd_we_sel", 64'({o_wb_we, o_wb_sel}),
            64'(m_owner == 0 ? {i_m0_we, i_m0_sel} : {i_m1_we, i_m1_sel}));
      end
      if (i_reset) begin
        m_owner = -1; m_abort = -1; m_last = 1; m_pend = 0; m_silent = 0;
      end else if (m_abort >= 0) begin
        m_abort = -1;
      end else if (m_owner < 0) begin
        if (c[0] && c[1]) m_owner = 1 - m_last;
        else if (c[0])    m_owner = 0;
        else if (c[1])    m_owner = 1;
        m_pend = 0; m_silent = 0;
      end else begin
        acc = estb && !i_wb_stall;
        if (m_silent == TO_MAIN) begin
          m_abort = m_owner; m_last = m_owner; m_owner = -1; m_pend = 0; m_silent = 0;
        end else if (!c[m_owner]) begin
          m_last = m_owner; m_owner = -1; m_pend = 0; m_silent = 0;
        end else begin
          m_silent = (i_wb_ack || m_pend == 0) ? 0 : m_silent + 1;
          m_pend = m_pend + int'(acc) - int'(ackf);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
